// File: rtl/uart_bus_master.sv
// UART-driven bus master: receives 'W'/'R' commands over 8N1 serial, stalls the core
// via hold_o, performs one word bus access and answers with 'K' or the read word.
module uart_bus_master #(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        hold_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    output logic [3:0]  data_w_o,
    input  logic [31:0] data_i
);
    localparam int unsigned CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

    // ---------------- receiver ----------------
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    rx_state_t rx_state, rx_state_n;

    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_sh, rx_sh_n;
    logic          rx_valid, rx_ferr;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_sh    <= rx_sh_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 1'b1;
        rx_bit_n   = rx_bit;
        rx_sh_n    = rx_sh;
        rx_valid   = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state)
            R_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_s2) rx_state_n = R_START;
            end
            R_START: begin
                // Line back high at mid start bit means a glitch, not a frame.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_s2 ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (rx_cnt == DIV_LAST) begin
                    rx_cnt_n = '0;
                    rx_sh_n  = {rx_s2, rx_sh[7:1]};
                    rx_bit_n = rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_state_n = R_STOP;
                end
            end
            R_STOP: begin
                if (rx_cnt == DIV_LAST) begin
                    rx_cnt_n   = '0;
                    rx_valid   = rx_s2;
                    rx_ferr    = !rx_s2;
                    rx_state_n = R_IDLE;
                end
            end
            default: rx_state_n = R_IDLE;
        endcase
    end

    // ---------------- transmitter ----------------
    logic          tx_busy;
    logic [9:0]    tx_sh;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic          tx_ready, tx_start;
    logic [7:0]    tx_byte;

    // A new byte may load on the very edge that ends the previous stop bit.
    assign tx_ready = !tx_busy || (tx_bit == 4'd9 && tx_cnt == DIV_LAST);
    assign uart_tx  = tx_busy ? tx_sh[0] : 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            tx_busy <= 1'b0;
            tx_sh   <= '1;
            tx_cnt  <= '0;
            tx_bit  <= '0;
        end else if (tx_start) begin
            tx_busy <= 1'b1;
            tx_sh   <= {1'b1, tx_byte, 1'b0};
            tx_cnt  <= '0;
            tx_bit  <= '0;
        end else if (tx_busy) begin
            if (tx_cnt == DIV_LAST) begin
                tx_cnt <= '0;
                tx_sh  <= {1'b1, tx_sh[9:1]};
                tx_bit <= tx_bit + 1'b1;
                if (tx_bit == 4'd9) tx_busy <= 1'b0;
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    // ---------------- command FSM ----------------
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS_REQ, BUS_ACC, BUS_RD, RESP, ACK} state_t;
    state_t state, state_n;

    logic [1:0]  cnt, cnt_n;
    logic        is_write, is_write_n;
    logic [31:0] addr_q, data_q, rd_q;
    logic        tail;
    logic        shift_addr, shift_data, latch_rd;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            is_write <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            rd_q     <= '0;
            tail     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            is_write <= is_write_n;
            if (shift_addr) addr_q <= {addr_q[23:0], rx_sh};
            if (shift_data) data_q <= {data_q[23:0], rx_sh};
            if (latch_rd)   rd_q   <= data_i;
            tail <= (state == BUS_ACC && is_write) || state == BUS_RD;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        is_write_n = is_write;
        shift_addr = 1'b0;
        shift_data = 1'b0;
        latch_rd   = 1'b0;
        tx_start   = 1'b0;
        tx_byte    = '0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (rx_valid && (rx_sh == 8'h57 || rx_sh == 8'h52)) begin
                    is_write_n = (rx_sh == 8'h57);
                    state_n    = ADDR;
                end
            end
            ADDR: begin
                if (rx_ferr) begin
                    state_n = IDLE;
                end else if (rx_valid) begin
                    shift_addr = 1'b1;
                    cnt_n      = cnt + 2'd1;
                    if (cnt == 2'd3) state_n = is_write ? DATA : BUS_REQ;
                end
            end
            DATA: begin
                if (rx_ferr) begin
                    state_n = IDLE;
                end else if (rx_valid) begin
                    shift_data = 1'b1;
                    cnt_n      = cnt + 2'd1;
                    if (cnt == 2'd3) state_n = BUS_REQ;
                end
            end
            BUS_REQ: begin
                cnt_n = cnt + 2'd1;
                if (cnt == 2'd1) begin
                    cnt_n   = '0;
                    state_n = BUS_ACC;
                end
            end
            BUS_ACC: state_n = is_write ? ACK : BUS_RD;
            BUS_RD: begin
                latch_rd = 1'b1;
                cnt_n    = '0;
                state_n  = RESP;
            end
            RESP: begin
                if (tx_ready) begin
                    tx_start = 1'b1;
                    case (cnt)
                        2'd0:    tx_byte = rd_q[31:24];
                        2'd1:    tx_byte = rd_q[23:16];
                        2'd2:    tx_byte = rd_q[15:8];
                        default: tx_byte = rd_q[7:0];
                    endcase
                    cnt_n = cnt + 2'd1;
                    if (cnt == 2'd3) state_n = IDLE;
                end
            end
            ACK: begin
                if (tx_ready) begin
                    tx_start = 1'b1;
                    tx_byte  = 8'h4B;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // hold_o covers BUS_REQ..BUS_RD plus one trailing cycle after the access.
    assign hold_o   = (state == BUS_REQ) || (state == BUS_ACC) || (state == BUS_RD) || tail;
    assign data_w_o = (state == BUS_ACC && is_write) ? 4'b1111 : 4'b0000;
    assign addr_o   = {addr_q[31:2], 2'b00};
    assign data_o   = data_q;

endmodule

// File: doc/uart_bus_master.md
UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 434, clocks per UART bit (50 MHz / 115200 baud).
REQ-002 SHALL have port clk_i, input, 1, the single system clock; all logic SHALL run on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port uart_rx, input, 1, asynchronous serial input, idle high.
REQ-005 SHALL have port uart_tx, output, 1, serial output, idle high.
REQ-006 SHALL have port hold_o, output, 1, requests that the SoC stall the core and route the memory bus to this block.
REQ-007 SHALL have port addr_o, output, 32, bus word address; bits [1:0] are always 00.
REQ-008 SHALL have port data_o, output, 32, bus write data.
REQ-009 SHALL have port data_w_o, output, 4, bus byte write enables.
REQ-010 SHALL have port data_i, input, 32, bus read data; valid one cycle after addr_o is presented.

Function
REQ-011 UART framing SHALL be 8N1, LSB first, CLK_DIV clocks per bit.
REQ-012 uart_rx SHALL pass through a 2-flop synchronizer before use.
REQ-013 RX start detection:
- a falling edge starts a candidate frame;
- the line is re-sampled at CLK_DIV/2; if it is high, the frame is discarded (glitch).
REQ-014 RX sampling: data bits are sampled at the bit centres; the stop bit is sampled at its centre; a low stop bit is a framing error and the byte is dropped.
REQ-015 Command FSM states SHALL be IDLE, ADDR, DATA, BUS_REQ, BUS_ACC, BUS_RD, RESP, ACK.
REQ-016 In IDLE:
- 0x57 ('W') → ADDR with write flag;
- 0x52 ('R') → ADDR with read flag;
- any other byte is ignored.
REQ-017 ADDR SHALL collect 4 bytes MSB first into addr_o[31:2]; received bits [1:0] are discarded.
REQ-018 After ADDR: a write goes to DATA; a read goes to BUS_REQ.
REQ-019 DATA SHALL collect 4 bytes MSB first; the first byte lands in data_o[31:24]; then → BUS_REQ.
REQ-020 A framing error in ADDR or DATA SHALL abort the command → IDLE, with no bus access and no response.
REQ-021 hold_o SHALL assert on entry to BUS_REQ and remain high for exactly 2 cycles before BUS_ACC, so the core pipeline can freeze.
REQ-022 BUS_ACC write: data_w_o=1111 for exactly one cycle → ACK.
REQ-023 BUS_ACC read: data_w_o=0000, addr_o held → BUS_RD; in BUS_RD, data_i is latched → RESP.
REQ-024 hold_o SHALL deassert in the cycle after BUS_ACC (write) or BUS_RD (read).
REQ-025 addr_o SHALL be stable from BUS_REQ entry until hold_o deasserts.
REQ-026 data_w_o SHALL be 0000 in every state other than write BUS_ACC.
REQ-027 RESP SHALL transmit the latched read word as 4 bytes MSB first, back-to-back, then → IDLE.
REQ-028 ACK SHALL transmit 0x4B ('K'), then → IDLE.
REQ-029 Bytes received while in BUS_REQ, BUS_ACC, BUS_RD, RESP or ACK SHALL be discarded.
REQ-030 TX SHALL send one byte at a time; the next byte starts in the cycle after the previous stop bit ends.

Reset
REQ-031 While rst_i=0 at a clock edge, outputs SHALL become:
- uart_tx=1, hold_o=0, addr_o=0, data_o=0, data_w_o=0000;
- FSM=IDLE; RX and TX idle.
REQ-032 Reset mid-command or mid-transfer SHALL abandon it immediately; any partial TX byte is truncated and the line is left high.

Verification
REQ-033 Write: 'W',40 00 00 10,DE AD BE EF → addr_o=0x40000010, data_o=0xDEADBEEF, data_w_o=1111 for exactly 1 cycle, hold_o high 4 cycles total, then TX 0x4B.
REQ-034 Read: 'R',40 00 00 13 with data_i=0x12345678 in BUS_RD cycle → addr_o=0x40000010, data_w_o=0000 throughout, TX 12 34 56 78.
REQ-035 Garbage 0x00,0xFF then a valid 'R' command → only the read executes; nothing is transmitted for the garbage bytes.
REQ-036 'W' with a low stop bit on address byte 2 → no hold_o, no TX; a following valid 'W' completes normally.
REQ-037 A 0.3-bit low glitch on uart_rx → no byte received; FSM stays IDLE.
REQ-038 rst_i=0 during the second byte of a read response → uart_tx=1 and hold_o=0 on the next edge; a new command after release works.
